game_round_controller: RTL and testbench
========================================

// Module: game_round_controller
// PURPOSE
//   Top-level sequencer for one Pac-Man game: IDLE -> READY -> PLAY -> DYING -> READY/GAME_OVER.
//   Owns the lives counter and the movement tick that gates all sprite position updates.
//   Owns the sprite respawn request and the ghost scatter/chase mode.
//   Sits beside the game-logic top: consumes pacman_is_dead, drives the move enable and respawn into position update.
// PARAMETERS
//   TICK_DIV      4'd? default 1_000_000  clk cycles per movement tick (>=2)
//   READY_TICKS   default 120   ticks spent in READY before play resumes (>=1)
//   DEATH_TICKS   default 90    ticks spent in DYING death animation (>=1)
//   LIVES_INIT    default 3     lives loaded at game start (1..2**LIVES_W-1)
//   LIVES_W       default 2     width of lives counter
//   SCATTER_TICKS default 420   PLAY ticks in scatter phase (GHOST_MODE_TIMER_EN only)
//   CHASE_TICKS   default 1200  PLAY ticks in chase phase (GHOST_MODE_TIMER_EN only)
// PORTS
//   clk            in   1        system clock
//   rst            in   1        synchronous reset, active-high
//   start_btn      in   1        start request (level; rising edge detected internally)
//   pacman_is_dead in   1        collision flag from collision detection, sampled every clk
//   move_en        out  1        one-clk pulse per tick while in PLAY; position updates advance only on it
//   sprite_rst     out  1        high in IDLE and READY: sprites held at reset positions
//   lives          out  LIVES_W  remaining lives
//   game_state     out  3        current FSM state encoding (shared header)
//   game_over      out  1        high while in GAME_OVER
//   ghost_chase    out  1        1 = chase target pacman, 0 = scatter to corners
// BEHAVIOUR
//   Reset (sync, rst=1 at posedge)
//   - State goes to IDLE and lives loads LIVES_INIT.
//   - move_en=0, sprite_rst=1, game_over=0, ghost_chase=0.
//   - Tick counter, phase timers and start edge register are all cleared.
//   - Reset mid-operation aborts any state; effective next clk.
//   Tick counter
//   - Free-running, counts 0..TICK_DIV-1 and wraps.
//   - tick is an internal pulse when count==TICK_DIV-1; never gated by state.
//   Phase timer
//   - Counts ticks and is reloaded to 0 on every state entry.
//   - done = (timer==LIMIT-1) && tick.
//   start_edge = start_btn & ~start_btn_q (registered).
//   State transitions
//   - IDLE: start_edge -> READY.
//   - READY: done(READY_TICKS) -> PLAY. start_edge ignored.
//   - PLAY: move_en=tick. pacman_is_dead=1 -> DYING, lives<=lives-1 (saturates at 0).
//     Death beats tick in the same cycle: move_en=0 that cycle.
//   - DYING: move_en=0, sprites frozen, pacman_is_dead ignored.
//     On done(DEATH_TICKS): lives==0 -> GAME_OVER, else -> READY (respawn).
//   - GAME_OVER: game_over=1. start_edge -> READY and lives reloads LIVES_INIT in the same cycle.
//   Timing and widths
//   - All outputs are registered; 1 clk latency from cause to output.
//   - Unused state codes recover to IDLE.
//   - Timer widths are $clog2 of their limit; no overflow because each timer resets on compare.
// CONFIGURATION
//   GHOST_MODE_TIMER_EN defined
//   - Mode timer advances on tick only in PLAY and pauses in DYING.
//   - Resets to scatter (ghost_chase=0) on READY entry.
//   - Toggles to chase after SCATTER_TICKS and back to scatter after CHASE_TICKS, repeating.
//   GHOST_MODE_TIMER_EN undefined
//   - ghost_chase is constant 1 after reset release (0 during rst cycle).
//   - Mode timer logic is not synthesized.
// STRUCTURE
//   - game_defs.vh (shared include): state codes IDLE=0, READY=1, PLAY=2, DYING=3, GAME_OVER=4.
//     Also holds the direction codes RIGHT/LEFT/UP/DOWN and the sprite IDs 0..4.
//   - Sub-module move_tick_gen: tick counter, params TICK_DIV, ports clk/rst/tick.
//   - FSM, lives and mode timer stay in this module.
// TESTING (TICK_DIV=4, READY_TICKS=2, DEATH_TICKS=3, LIVES_INIT=2, SCATTER=5, CHASE=10)
//   1. Reset then start pulse -> READY next clk; sprite_rst=1 for 8 clks; PLAY; move_en every 4th clk.
//   2. In PLAY assert pacman_is_dead on a tick cycle -> move_en=0 that cycle, DYING, lives 2->1;
//      after 12 clks -> READY -> PLAY.
//   3. Second death -> lives 0, DYING 12 clks -> GAME_OVER, game_over=1;
//      start pulse -> READY with lives=2.
//   4. Assert rst mid-DYING -> next clk IDLE, lives=2, move_en=0, sprite_rst=1;
//      holding start_btn high through rst starts no game until it is re-pressed.
//   5. With GHOST_MODE_TIMER_EN: ghost_chase 0 for 5 PLAY ticks, then 1 for 10, then 0.
//      The timer holds through DYING and restarts at scatter after respawn.
//   6. Without the macro, ghost_chase=1 in all states; start_btn held high in READY/PLAY has no effect.

Source files
------------

// File: rtl/game_round_controller_pkg.sv
// Shared definitions for the Pac-Man round controller: FSM state codes,
// direction codes, sprite IDs and a counter-width helper.
package game_round_controller_pkg;

  // Round sequencer states; codes are shared with the game-logic top.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READY     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_DYING     = 3'd3,
    ST_GAME_OVER = 3'd4
  } game_state_e;

  // Sprite movement directions.
  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_e;

  // Sprite identifiers.
  localparam logic [2:0] SPRITE_PACMAN = 3'd0;
  localparam logic [2:0] SPRITE_BLINKY = 3'd1;
  localparam logic [2:0] SPRITE_PINKY  = 3'd2;
  localparam logic [2:0] SPRITE_INKY   = 3'd3;
  localparam logic [2:0] SPRITE_CLYDE  = 3'd4;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/game_round_controller_move_tick_gen.sv
// Free-running movement tick divider: tick pulses for one clk every
// TICK_DIV clks, independent of game state.
module move_tick_gen #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q;

  // Count 0..TICK_DIV-1 and wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (count_q == LAST) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(1);
    end
  end

  assign tick = (count_q == LAST);

endmodule

// File: rtl/game_round_controller.sv
// Pac-Man round sequencer: IDLE -> READY -> PLAY -> DYING -> READY/GAME_OVER.
// Owns lives, the movement enable, the sprite respawn hold and ghost mode.
// Optional macro GHOST_MODE_TIMER_EN: scatter/chase mode timer running on
// PLAY ticks; without it ghost_chase is fixed at 1 once out of reset.
//
// Handshake note: there is no valid/ready traffic here. start_btn is a level
// whose rising edge is the request; pacman_is_dead is sampled every clk;
// move_en is a one-clk strobe consumers must act on in that clk only.
module game_round_controller
  import game_round_controller_pkg::*;
#(
  parameter int TICK_DIV      = 1_000_000,
  parameter int READY_TICKS   = 120,
  parameter int DEATH_TICKS   = 90,
  parameter int LIVES_INIT    = 3,
  parameter int LIVES_W       = 2,
  parameter int SCATTER_TICKS = 420,
  parameter int CHASE_TICKS   = 1200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic               pacman_is_dead,
  output logic               move_en,
  output logic               sprite_rst,
  output logic [LIVES_W-1:0] lives,
  output logic [2:0]         game_state,
  output logic               game_over,
  output logic               ghost_chase
);

  localparam int PHASE_MAX = (READY_TICKS > DEATH_TICKS) ? READY_TICKS : DEATH_TICKS;
  localparam int PW = cnt_width(PHASE_MAX);
  localparam logic [PW-1:0] READY_LAST = PW'(READY_TICKS - 1);
  localparam logic [PW-1:0] DEATH_LAST = PW'(DEATH_TICKS - 1);
  localparam logic [LIVES_W-1:0] LIVES_RELOAD = LIVES_W'(LIVES_INIT);

  // Reject parameter sets the counters cannot represent.
  if (TICK_DIV < 2 || READY_TICKS < 1 || DEATH_TICKS < 1 || SCATTER_TICKS < 1 ||
      CHASE_TICKS < 1 || LIVES_INIT < 1 || LIVES_INIT >= (2 ** LIVES_W)) begin : g_param_check
    $error("game_round_controller: parameter out of range");
  end

  logic tick;

  move_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  game_state_e        state_q, state_d;
  logic [PW-1:0]      phase_q, phase_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               start_q;
  logic               start_edge;
  logic               move_en_q, sprite_rst_q, game_over_q;

  assign start_edge = start_btn & ~start_q;

  // Next state, lives and phase timer; timer restarts on every state entry.
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    phase_d = phase_q;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) state_d = ST_READY;
      end
      ST_READY: begin
        if (tick && phase_q == READY_LAST) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (pacman_is_dead) begin
          state_d = ST_DYING;
          lives_d = (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);
        end
      end
      ST_DYING: begin
        if (tick && phase_q == DEATH_LAST) begin
          state_d = (lives_q == '0) ? ST_GAME_OVER : ST_READY;
        end
      end
      ST_GAME_OVER: begin
        if (start_edge) begin
          state_d = ST_READY;
          lives_d = LIVES_RELOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) begin
      phase_d = '0;
    end else if (tick && (state_q == ST_READY || state_q == ST_DYING)) begin
      phase_d = phase_q + PW'(1);
    end
  end

  // State, lives and registered outputs; a start level held through reset
  // is captured so it is not mistaken for a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      lives_q      <= LIVES_RELOAD;
      phase_q      <= '0;
      start_q      <= start_btn;
      move_en_q    <= 1'b0;
      sprite_rst_q <= 1'b1;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      phase_q      <= phase_d;
      start_q      <= start_btn;
      move_en_q    <= (state_q == ST_PLAY) && tick && !pacman_is_dead;
      sprite_rst_q <= (state_d == ST_IDLE) || (state_d == ST_READY);
      game_over_q  <= (state_d == ST_GAME_OVER);
    end
  end

`ifdef GHOST_MODE_TIMER_EN
  localparam int MW = cnt_width((SCATTER_TICKS > CHASE_TICKS) ? SCATTER_TICKS : CHASE_TICKS);
  localparam logic [MW-1:0] SCATTER_LAST = MW'(SCATTER_TICKS - 1);
  localparam logic [MW-1:0] CHASE_LAST   = MW'(CHASE_TICKS - 1);

  logic [MW-1:0] mode_q;
  logic          chase_q;

  // Scatter/chase alternation on PLAY ticks; frozen elsewhere, scatter on READY entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= '0;
      chase_q <= 1'b0;
    end else if (state_d == ST_READY && state_q != ST_READY) begin
      mode_q  <= '0;
      chase_q <= 1'b0;
    end else if (state_q == ST_PLAY && tick) begin
      if (!chase_q && mode_q == SCATTER_LAST) begin
        mode_q  <= '0;
        chase_q <= 1'b1;
      end else if (chase_q && mode_q == CHASE_LAST) begin
        mode_q  <= '0;
        chase_q <= 1'b0;
      end else begin
        mode_q <= mode_q + MW'(1);
      end
    end
  end
`else
  logic chase_q;

  // Ghosts always chase once reset is released.
  always_ff @(posedge clk) begin
    if (rst) chase_q <= 1'b0;
    else     chase_q <= 1'b1;
  end
`endif

  assign move_en     = move_en_q;
  assign sprite_rst  = sprite_rst_q;
  assign lives       = lives_q;
  assign game_state  = state_q;
  assign game_over   = game_over_q;
  assign ghost_chase = chase_q;

endmodule

// File: tb/tb_game_round_controller.sv
// Directed bench for game_round_controller with small timing parameters.
// Cycle n is the interval after the n-th posedge following the last reset edge.
module tb_game_round_controller;

  localparam int TICK_DIV = 4;
  localparam int LIVES_W  = 2;

  logic clk = 1'b0;
  logic rst;
  logic start_btn;
  logic pacman_is_dead;
  logic move_en;
  logic sprite_rst;
  logic [LIVES_W-1:0] lives;
  logic [2:0] game_state;
  logic game_over;
  logic ghost_chase;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Clock and reset-relative cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  game_round_controller #(
    .TICK_DIV(TICK_DIV), .READY_TICKS(2), .DEATH_TICKS(3), .LIVES_INIT(2),
    .LIVES_W(LIVES_W), .SCATTER_TICKS(5), .CHASE_TICKS(10)
  ) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .pacman_is_dead(pacman_is_dead),
    .move_en(move_en), .sprite_rst(sprite_rst), .lives(lives),
    .game_state(game_state), .game_over(game_over), .ghost_chase(ghost_chase)
  );

  // Advance to 1 time unit after the posedge opening cycle n.
  task automatic go(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    start_btn = 1'b0;
    pacman_is_dead = 1'b0;
    do_reset();
    checks++; if (game_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", game_state); end
    checks++; if (lives !== 2'd2) begin errors++; $display("FAIL reset_lives: got %0d expected 2", lives); end
    checks++; if (move_en !== 1'b0 || sprite_rst !== 1'b1 || game_over !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: move_en=%b sprite_rst=%b game_over=%b expected 0 1 0", move_en, sprite_rst, game_over); end
    checks++; if (ghost_chase !== 1'b0) begin errors++; $display("FAIL reset_ghost: got %b expected 0", ghost_chase); end
    go(1);
`ifndef GHOST_MODE_TIMER_EN
    checks++; if (ghost_chase !== 1'b1) begin errors++; $display("FAIL ghost_after_reset: got %b expected 1", ghost_chase); end
`endif
    checks++; if (game_state !== 3'd0) begin errors++; $display("FAIL idle_hold: got %0d expected 0", game_state); end
  endtask

  task automatic test_start_play();
    go(3); start_btn = 1'b1;
    for (int n = 4; n <= 11; n++) begin
      go(n);
      if (n == 5) start_btn = 1'b0;
      checks++; if (game_state !== 3'd1 || sprite_rst !== 1'b1) begin
        errors++; $display("FAIL ready_hold c%0d: state=%0d sprite_rst=%b expected 1 1", n, game_state, sprite_rst); end
    end
    go(12);
    checks++; if (game_state !== 3'd2 || sprite_rst !== 1'b0) begin
      errors++; $display("FAIL play_entry: state=%0d sprite_rst=%b expected 2 0", game_state, sprite_rst); end
    for (int n = 12; n <= 24; n++) begin
      go(n);
      checks++; if (move_en !== (n == 16 || n == 20 || n == 24)) begin
        errors++; $display("FAIL move_en c%0d: got %b expected %b", n, move_en, (n == 16 || n == 20 || n == 24)); end
`ifndef GHOST_MODE_TIMER_EN
      checks++; if (ghost_chase !== 1'b1) begin errors++; $display("FAIL ghost_play c%0d: got %b expected 1", n, ghost_chase); end
`endif
    end
  endtask

  task automatic test_death_respawn();
    go(27); pacman_is_dead = 1'b1;
    go(28); pacman_is_dead = 1'b0;
    checks++; if (game_state !== 3'd3 || lives !== 2'd1) begin
      errors++; $display("FAIL death1: state=%0d lives=%0d expected 3 1", game_state, lives); end
    checks++; if (move_en !== 1'b0 || sprite_rst !== 1'b0) begin
      errors++; $display("FAIL death_beats_tick: move_en=%b sprite_rst=%b expected 0 0", move_en, sprite_rst); end
    go(30); pacman_is_dead = 1'b1;
    go(32); pacman_is_dead = 1'b0;
    go(39);
    checks++; if (game_state !== 3'd3 || lives !== 2'd1) begin
      errors++; $display("FAIL dying_hold: state=%0d lives=%0d expected 3 1", game_state, lives); end
    go(40);
    checks++; if (game_state !== 3'd1 || sprite_rst !== 1'b1) begin
      errors++; $display("FAIL respawn_ready: state=%0d sprite_rst=%b expected 1 1", game_state, sprite_rst); end
    go(47);
    checks++; if (game_state !== 3'd1) begin errors++; $display("FAIL respawn_ready_hold: got %0d expected 1", game_state); end
    go(48);
    checks++; if (game_state !== 3'd2) begin errors++; $display("FAIL respawn_play: got %0d expected 2", game_state); end
  endtask

  task automatic test_game_over_restart();
    go(51); pacman_is_dead = 1'b1;
    go(52); pacman_is_dead = 1'b0;
    checks++; if (game_state !== 3'd3 || lives !== 2'd0) begin
      errors++; $display("FAIL death2: state=%0d lives=%0d expected 3 0", game_state, lives); end
    go(63);
    checks++; if (game_state !== 3'd3 || game_over !== 1'b0) begin
      errors++; $display("FAIL dying2_hold: state=%0d game_over=%b expected 3 0", game_state, game_over); end
    go(64);
    checks++; if (game_state !== 3'd4 || game_over !== 1'b1 || lives !== 2'd0) begin
      errors++; $display("FAIL game_over: state=%0d game_over=%b lives=%0d expected 4 1 0", game_state, game_over, lives); end
    go(65); start_btn = 1'b1;
    go(66); start_btn = 1'b0;
    checks++; if (game_state !== 3'd1 || lives !== 2'd2 || game_over !== 1'b0) begin
      errors++; $display("FAIL restart: state=%0d lives=%0d game_over=%b expected 1 2 0", game_state, lives, game_over); end
    go(72);
    checks++; if (game_state !== 3'd2) begin errors++; $display("FAIL restart_play: got %0d expected 2", game_state); end
  endtask

  task automatic test_reset_mid_dying();
    go(73); pacman_is_dead = 1'b1;
    go(74); pacman_is_dead = 1'b0;
    checks++; if (game_state !== 3'd3 || lives !== 2'd1) begin
      errors++; $display("FAIL death3: state=%0d lives=%0d expected 3 1", game_state, lives); end
    go(76); rst = 1'b1; start_btn = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (game_state !== 3'd0 || lives !== 2'd2 || move_en !== 1'b0 || sprite_rst !== 1'b1) begin
      errors++; $display("FAIL mid_reset: state=%0d lives=%0d move_en=%b sprite_rst=%b expected 0 2 0 1", game_state, lives, move_en, sprite_rst); end
    go(3);
    checks++; if (game_state !== 3'd0) begin errors++; $display("FAIL held_start: got %0d expected 0", game_state); end
    start_btn = 1'b0;
    go(4); start_btn = 1'b1;
    go(5);
    checks++; if (game_state !== 3'd1) begin errors++; $display("FAIL repress: got %0d expected 1", game_state); end
    start_btn = 1'b0;
  endtask

  task automatic test_start_ignored();
    go(6); start_btn = 1'b1;
    go(8);
    checks++; if (game_state !== 3'd1) begin errors++; $display("FAIL ready_start_ign: got %0d expected 1", game_state); end
    go(11);
    checks++; if (game_state !== 3'd1) begin errors++; $display("FAIL ready_timing: got %0d expected 1", game_state); end
    go(12); start_btn = 1'b0;
    checks++; if (game_state !== 3'd2) begin errors++; $display("FAIL play_after_ready: got %0d expected 2", game_state); end
    go(13); start_btn = 1'b1;
    go(15);
    checks++; if (game_state !== 3'd2) begin errors++; $display("FAIL play_start_ign: got %0d expected 2", game_state); end
    go(16);
    checks++; if (move_en !== 1'b1) begin errors++; $display("FAIL move_en_after_rst: got %b expected 1", move_en); end
`ifndef GHOST_MODE_TIMER_EN
    checks++; if (ghost_chase !== 1'b1) begin errors++; $display("FAIL ghost_const: got %b expected 1", ghost_chase); end
`endif
    start_btn = 1'b0;
  endtask

`ifdef GHOST_MODE_TIMER_EN
  task automatic test_ghost_mode();
    int k;
    bit exp_c;
    bit seen_ready;
    start_btn = 1'b0;
    pacman_is_dead = 1'b0;
    do_reset();
    go(1); start_btn = 1'b1;
    go(3); start_btn = 1'b0;
    k = 0;
    for (int c = 0; c < 200 && k < 21; c++) begin
      @(posedge clk); #1;
      if (move_en) begin
        k++;
        exp_c = (k >= 5) && (((k - 5) % 15) < 10);
        checks++; if (ghost_chase !== exp_c) begin
          errors++; $display("FAIL ghost_tick%0d: got %b expected %b", k, ghost_chase, exp_c); end
      end
    end
    checks++; if (k != 21) begin errors++; $display("FAIL ghost_timeout: got %0d pulses expected 21", k); end
    pacman_is_dead = 1'b1;
    @(posedge clk); #1;
    pacman_is_dead = 1'b0;
    checks++; if (game_state !== 3'd3) begin errors++; $display("FAIL ghost_death: got %0d expected 3", game_state); end
    seen_ready = 1'b0;
    for (int c = 0; c < 40 && !seen_ready; c++) begin
      if (game_state == 3'd1) begin
        seen_ready = 1'b1;
        checks++; if (ghost_chase !== 1'b0) begin errors++; $display("FAIL ghost_respawn: got %b expected 0", ghost_chase); end
      end else begin
        checks++; if (ghost_chase !== 1'b1) begin errors++; $display("FAIL ghost_dying_hold: got %b expected 1", ghost_chase); end
        @(posedge clk); #1;
      end
    end
    checks++; if (!seen_ready) begin errors++; $display("FAIL ghost_ready_timeout: got 0 expected 1"); end
  endtask
`endif

  // Watchdog: every wait above is bounded, this is a last resort.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Scenario sequence.
  initial begin
    rst = 1'b1;
    start_btn = 1'b0;
    pacman_is_dead = 1'b0;
    test_reset();
    test_start_play();
    test_death_respawn();
    test_game_over_restart();
    test_reset_mid_dying();
    test_start_ignored();
`ifdef GHOST_MODE_TIMER_EN
    test_ghost_mode();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
